instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the maximum number of words written per session.
REQ-002 The block SHALL have parameter CNT_W, default 9, giving the width of count; CNT_W SHALL satisfy 2^CNT_W > DEPTH.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  opens a session.
- base_addr  in  32  byte address of the first word.
- stop  in  1  ends the session.
- in_valid  in  1  instruction-field request valid.
- in_ready  out  1  block can accept a request.
- fmt  in  4  format: 0 R, 1 I-arith, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE; 11-15 illegal.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7b5  in  1  instruction bit 30 for R-type and shift-immediate.
- imm  in  32  signed immediate, or byte offset for branch/jump.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  write byte address.
- mem_wdata  out  32  encoded instruction word.
- mem_ack  in  1  memory accepted the write.
- count  out  CNT_W  words written in the current session.
- done  out  1  session ended.
- err  out  1  sticky illegal-format flag.

Function
REQ-004 The FSM SHALL have four states: IDLE, ACCEPT, WRITE, DONE.
REQ-005 From IDLE or DONE, start=1 SHALL cause a transition to ACCEPT and load mem_addr=base_addr, count=0, done=0 and err=0; in ACCEPT and WRITE, start SHALL be ignored.
REQ-006 in_ready SHALL equal (state==ACCEPT && !stop); stop=1 in ACCEPT SHALL cause a transition to DONE, and stop SHALL win over a simultaneous in_valid.
REQ-007 A transfer SHALL occur when in_valid && in_ready; on that edge the block SHALL register the encoded word into mem_wdata, set mem_we=1 and enter WRITE, so that mem_we is high on the cycle after the transfer.
REQ-008 A transfer with an illegal fmt SHALL be consumed without a write: err is set to 1, the FSM stays in ACCEPT, and count and mem_addr are unchanged.
REQ-009 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until the edge on which mem_ack=1.
REQ-010 On that edge the block SHALL set mem_we=0, add 4 to mem_addr (modulo 2^32) and add 1 to count.
REQ-011 After that edge the FSM SHALL go to DONE if the new count equals DEPTH, and otherwise back to ACCEPT.
REQ-012 mem_ack SHALL be ignored outside WRITE.
REQ-013 done SHALL be 1 exactly while the FSM is in DONE; in DONE, in_ready=0 and mem_we=0.
REQ-014 Bits [6:0] of every encoded word SHALL be the base opcode with 2'b11 appended. Base opcodes: R 01100, I-arith 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101, SYSTEM 11100, FENCE 00011.
REQ-015 Fields SHALL be placed as follows:
- R: {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
- I-arith and LOAD: {imm[11:0], rs1, funct3, rd, op}. For I-arith with funct3 = 001 or 101, bits [31:25] = {0,funct7b5,00000} and bits [24:20] = imm[4:0].
- STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; imm[0] ignored.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- JALR: funct3 forced to 000; otherwise as I-arith without the shift rule.
- LUI and AUIPC: {imm[31:12], rd, op}.
- SYSTEM: 0x00000073 when imm[0]=0 (ECALL), 0x00100073 when imm[0]=1 (EBREAK).
- FENCE: {0000, imm[7:0], 00000, 000, 00000, op}.
- Immediate bits not listed are ignored; no range checking is performed.
REQ-016 count SHALL never exceed DEPTH, and a session SHALL never produce more than DEPTH writes.

Reset
REQ-017 On a clock edge with rst=0 the block SHALL enter IDLE and set mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0 and err=0; in_ready SHALL then be 0.
REQ-018 A reset asserted during WRITE SHALL drop mem_we on that same edge, and any mem_ack in that cycle SHALL be discarded.
REQ-019 After rst returns to 1, the block SHALL stay in IDLE until start=1.

Verification
REQ-020 R-type write: base_addr=0x100, start, then fmt=0, rd=3, rs1=1, rs2=2, funct3=0, funct7b5=0 with mem_ack=1 -> one write mem_addr=0x100, mem_wdata=0x002081B3. Same with funct7b5=1 -> 0x402081B3 at 0x104; count=2.
REQ-021 Immediate formats: fmt=5, rd=1, imm=8 -> 0x008000EF. fmt=4, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC -> 0xFE208EE3. fmt=9, imm=1 -> 0x00100073.
REQ-022 Memory stall: mem_ack held 0 for 3 cycles -> mem_we, mem_addr and mem_wdata remain stable and in_ready=0; on the ack cycle mem_we drops next edge and mem_addr advances by 4.
REQ-023 Full session: DEPTH=4, in_valid held 1, mem_ack=1 -> writes at base, +4, +8, +12; then count=4, done=1, in_ready=0 and no fifth write; start afterwards restarts with count=0.
REQ-024 Edge cases:
- fmt=12 accepted -> err=1, no mem_we, count unchanged.
- stop and in_valid together in ACCEPT -> no transfer, done=1.
- rst=0 during WRITE -> mem_we=0 and FSM in IDLE after that edge.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction-field requests into 32-bit words and writes them
// to instruction memory at consecutive word addresses, one session at a time.
module instr_encoder_loader #(
   parameter int DEPTH = 256,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic             stop,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       fmt,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic [31:0]      imm,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             err,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state;
   logic [31:0]      enc_word;
   logic             fmt_ok;
   logic [CNT_W-1:0] count_inc;

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // in_valid may be held across cycles, and stop blocks in_ready combinationally.
   assign in_ready  = (state == ACCEPT) && !stop;
   assign count_inc = count + CNT_W'(1);
   assign dbg_state = state;

   always_comb begin
      enc_word = 32'd0;
      fmt_ok   = 1'b1;
      case (fmt)
         4'd0:  enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
         4'd1: begin
            // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
            if (funct3 == 3'b001 || funct3 == 3'b101)
               enc_word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IARITH};
            else
               enc_word = {imm[11:0], rs1, funct3, rd, OP_IARITH};
         end
         4'd2:  enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
         4'd3:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
         4'd4:  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
         4'd5:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         4'd6:  enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
         4'd7:  enc_word = {imm[31:12], rd, OP_LUI};
         4'd8:  enc_word = {imm[31:12], rd, OP_AUIPC};
         4'd9:  enc_word = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
         4'd10: enc_word = {4'b0000, imm[7:0], 5'b00000, 3'b000, 5'b00000, OP_FENCE};
         default: fmt_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         count     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= ACCEPT;
                  mem_addr <= base_addr;
                  count    <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            ACCEPT: begin
               if (stop) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (in_valid) begin
                  if (fmt_ok) begin
                     mem_wdata <= enc_word;
                     mem_we    <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_we   <= 1'b0;
                  mem_addr <= mem_addr + 32'd4;
                  count    <= count_inc;
                  if (count_inc == DEPTH_C) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ACCEPT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed scoreboard bench for instr_encoder_loader: expected writes are queued
// at issue time and a negedge monitor pops and compares each completed write.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam logic [1:0] S_IDLE = 2'd0, S_ACCEPT = 2'd1, S_WRITE = 2'd2, S_DONE = 2'd3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base_addr;
   logic             stop;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       fmt;
   logic [4:0]       rd, rs1, rs2;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic [31:0]      imm;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             mem_ack;
   logic [CNT_W-1:0] count;
   logic             done;
   logic             err;
   logic [1:0]       dbg_state;

   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] exp_addr;
   int          total = 0;
   int          bad = 0;

   instr_encoder_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .rd(rd), .rs1(rs1),
      .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .count(count), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // monitor: a write completes on the edge after a negedge with mem_we && mem_ack
   always @(negedge clk) begin
      if (rst === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", {32'd0, mem_addr}, {32'd0, mon_e[63:32]});
            check("write_data", {32'd0, mem_wdata}, {32'd0, mon_e[31:0]});
         end
      end
   end

   // driver tasks
   task automatic do_start(input logic [31:0] base);
      @(posedge clk); #1;
      base_addr = base;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      exp_addr  = base;
   endtask

   task automatic send(input logic [3:0] f, input logic [4:0] d, s1, s2,
                       input logic [2:0] f3, input logic f7, input logic [31:0] im,
                       input logic [31:0] exp_word, input bit push);
      bit ok;
      ok = 1'b0;
      if (push) begin
         exp_q.push_back({exp_addr, exp_word});
         exp_addr += 32'd4;
      end
      @(posedge clk); #1;
      fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
      in_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_accepted", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mem_we) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", {63'd0, ok}, 64'd1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = 32'd0; stop = 1'b0; in_valid = 1'b0;
      fmt = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      imm = 32'd0; mem_ack = 1'b1; exp_addr = 32'd0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_we", {63'd0, mem_we}, 64'd0);
      check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
      check("rst_count", {61'd0, count}, 64'd0);
      check("rst_done_err", {62'd0, done, err}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_hold_state", {62'd0, dbg_state}, {62'd0, S_IDLE});

      // session A: R-types, JAL, BRANCH fill the session
      do_start(32'h0000_0100);
      check("start_state", {62'd0, dbg_state}, {62'd0, S_ACCEPT});
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h0020_81B3, 1'b1);
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h4020_81B3, 1'b1);
      wait_drain();
      check("a_count2", {61'd0, count}, 64'd2);
      send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 32'h0080_00EF, 1'b1);
      send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b1);
      wait_drain();
      check("a_count4", {61'd0, count}, 64'd4);
      check("a_done", {63'd0, done}, 64'd1);
      check("a_in_ready", {63'd0, in_ready}, 64'd0);
      check("a_state", {62'd0, dbg_state}, {62'd0, S_DONE});

      // session B: EBREAK, memory stall, illegal format, STORE, stop
      do_start(32'h0000_2000);
      check("b_done_clr", {63'd0, done}, 64'd0);
      send(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 32'h0010_0073, 1'b1);
      wait_drain();
      mem_ack = 1'b0;
      send(4'd1, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 32'hFFFF_FFE3, 32'h4033_5293, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_we", {63'd0, mem_we}, 64'd1);
         check("stall_addr", {32'd0, mem_addr}, 64'h2004);
         check("stall_data", {32'd0, mem_wdata}, 64'h4033_5293);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1 mem_ack = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("ack_we_drop", {63'd0, mem_we}, 64'd0);
      check("ack_addr", {32'd0, mem_addr}, 64'h2008);
      check("ack_count", {61'd0, count}, 64'd2);
      send(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("illegal_err", {63'd0, err}, 64'd1);
      check("illegal_we", {63'd0, mem_we}, 64'd0);
      check("illegal_count", {61'd0, count}, 64'd2);
      check("illegal_addr", {32'd0, mem_addr}, 64'h2008);
      check("illegal_state", {62'd0, dbg_state}, {62'd0, S_ACCEPT});
      send(4'd3, 5'd0, 5'd3, 5'd2, 3'b010, 1'b0, 32'd8, 32'h0021_A423, 1'b1);
      wait_drain();
      check("err_sticky", {63'd0, err}, 64'd1);
      @(posedge clk); #1;
      stop = 1'b1; in_valid = 1'b1; fmt = 4'd0;
      @(negedge clk);
      check("stop_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      stop = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("stop_done", {63'd0, done}, 64'd1);
      check("stop_count", {61'd0, count}, 64'd3);
      check("stop_we", {63'd0, mem_we}, 64'd0);

      // session C: continuous in_valid, address wrap, DEPTH limit, restart
      do_start(32'hFFFF_FFF8);
      check("c_err_clr", {63'd0, err}, 64'd0);
      check("c_count0", {61'd0, count}, 64'd0);
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back({exp_addr, 32'hFFF0_0093});
         exp_addr += 32'd4;
      end
      @(posedge clk); #1;
      fmt = 4'd1; rd = 5'd1; rs1 = 5'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      imm = 32'hFFFF_FFFF; in_valid = 1'b1;
      begin
         bit ok;
         ok = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
               ok = 1'b1;
               break;
            end
         end
         check("c_done_reached", {63'd0, ok}, 64'd1);
      end
      repeat (4) @(negedge clk);
      check("c_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("c_count4", {61'd0, count}, 64'd4);
      check("c_we", {63'd0, mem_we}, 64'd0);
      check("c_addr_wrap", {32'd0, mem_addr}, 64'h8);
      check("c_queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
      do_start(32'h0000_0300);
      @(negedge clk);
      check("restart_count", {61'd0, count}, 64'd0);
      check("restart_done", {63'd0, done}, 64'd0);

      // session D: LUI, FENCE, JALR, LOAD
      send(4'd7, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5ABC, 32'h1234_5537, 1'b1);
      send(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_00FF, 32'h0FF0_000F, 1'b1);
      send(4'd6, 5'd1, 5'd5, 5'd0, 3'd7, 1'b0, 32'h0000_0010, 32'h0102_80E7, 1'b1);
      send(4'd2, 5'd4, 5'd2, 5'd0, 3'b010, 1'b0, 32'hFFFF_FFFC, 32'hFFC1_2203, 1'b1);
      wait_drain();
      check("d_done", {63'd0, done}, 64'd1);

      // session E: AUIPC, then reset during a stalled write
      do_start(32'h0000_0400);
      send(4'd8, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_1000, 32'h0000_1197, 1'b1);
      wait_drain();
      mem_ack = 1'b0;
      send(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("ecall_we", {63'd0, mem_we}, 64'd1);
      check("ecall_data", {32'd0, mem_wdata}, 64'h0000_0073);
      check("ecall_addr", {32'd0, mem_addr}, 64'h404);
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("wrst_we", {63'd0, mem_we}, 64'd0);
      check("wrst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      check("wrst_count", {61'd0, count}, 64'd0);
      check("wrst_addr", {32'd0, mem_addr}, 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("post_rst_we", {63'd0, mem_we}, 64'd0);
      check("final_queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
